memory_responder: RTL and testbench

Memory-side responder for the processor's memory handshake. The control unit raises `MOV` with `RW`, size and address, then stalls until `MOC`; this block captures the request, waits a programmable latency, and performs the access on a byte-addressed, big-endian RAM. It returns `MOC`, plus `ERR` for illegal accesses. It sits between the datapath's MAR/MDR and the control unit's `MOC` input and serves both instruction fetch and load/store.

---
 rtl/memory_responder.sv | 205 ++++++++++++++++++++
 tb/tb_memory_responder.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_responder.sv
// memory_responder
// Memory-side responder for a MOV/MOC four-phase handshake. A request is
// captured in IDLE, held for a programmable latency, then performed on a
// byte-addressed big-endian RAM. Misaligned and reserved-size accesses are
// rejected with ERR alongside MOC and leave the RAM untouched.
module memory_responder #(
    parameter int unsigned DEPTH   = 512,
    parameter int unsigned LATENCY = 2
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        MOV,
    input  logic        RW,
    input  logic [1:0]  size,
    input  logic        sign,
    input  logic [31:0] addr,
    input  logic [31:0] data_in,
    output logic [31:0] data_out,
    output logic        MOC,
    output logic        ERR
);

    localparam int unsigned AW       = $clog2(DEPTH);
    localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);
    localparam logic [1:0]  SZ_BYTE  = 2'b00;
    localparam logic [1:0]  SZ_HALF  = 2'b01;
    localparam logic [1:0]  SZ_WORD  = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    // Storage: deliberately outside the reset domain so contents survive clr.
    logic [7:0] mem [0:DEPTH-1];

    state_t      state_q;
    logic [3:0]  cnt_q;
    logic        rw_q;
    logic [1:0]  size_q;
    logic        sign_q;
    logic [AW-1:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] data_out_q;
    logic        moc_q;
    logic        err_q;

    logic [AW-1:0] idx0_s;
    logic [AW-1:0] idx1_s;
    logic [AW-1:0] idx2_s;
    logic [AW-1:0] idx3_s;
    logic          err_s;
    logic          access_s;
    logic          wr_en_s;
    logic [31:0]   rdata_s;

    // Address bits above the RAM size are ignored so addresses wrap.
    logic unused_addr_s;
    assign unused_addr_s = ^addr[31:AW];

    // Zero- or sign-extend a byte to 32 bits.
    function automatic logic [31:0] ext8(input logic [7:0] b, input logic sx);
        logic [31:0] r;
        if (sx) r = {{24{b[7]}}, b};
        else    r = {24'h00_0000, b};
        return r;
    endfunction

    // Zero- or sign-extend a halfword to 32 bits.
    function automatic logic [31:0] ext16(input logic [15:0] h, input logic sx);
        logic [31:0] r;
        if (sx) r = {{16{h[15]}}, h};
        else    r = {16'h0000, h};
        return r;
    endfunction

    // Byte lanes of the latched address; only aligned accesses reach the RAM,
    // so OR-ing in the lane offset equals adding it.
    always_comb begin
        idx0_s = addr_q;
        idx1_s = addr_q | AW'(2'b01);
        idx2_s = addr_q | AW'(2'b10);
        idx3_s = addr_q | AW'(2'b11);
    end

    // Reject reserved size and misaligned halfword/word accesses.
    always_comb begin
        err_s = 1'b0;
        case (size_q)
            SZ_BYTE: err_s = 1'b0;
            SZ_HALF: err_s = addr_q[0];
            SZ_WORD: err_s = (addr_q[1:0] != 2'b00);
            default: err_s = 1'b1;
        endcase
    end

    // Big-endian read of the latched request, extended to 32 bits.
    always_comb begin
        rdata_s = 32'h0000_0000;
        case (size_q)
            SZ_BYTE: rdata_s = ext8(mem[idx0_s], sign_q);
            SZ_HALF: rdata_s = ext16({mem[idx0_s], mem[idx1_s]}, sign_q);
            SZ_WORD: rdata_s = {mem[idx0_s], mem[idx1_s], mem[idx2_s], mem[idx3_s]};
            default: rdata_s = 32'h0000_0000;
        endcase
    end

    // The access happens on the edge that finds BUSY expired with MOV still high;
    // a simultaneous MOV drop aborts instead.
    always_comb begin
        access_s = 1'b0;
        if ((state_q == ST_BUSY) && MOV && (cnt_q == 4'd0)) begin
            access_s = 1'b1;
        end else begin
            access_s = 1'b0;
        end
        wr_en_s = access_s & ~rw_q & ~err_s;
    end

    // RAM write port, big-endian lane placement, no reset on the array.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            case (size_q)
                SZ_BYTE: mem[idx0_s] <= wdata_q[7:0];
                SZ_HALF: begin
                    mem[idx0_s] <= wdata_q[15:8];
                    mem[idx1_s] <= wdata_q[7:0];
                end
                SZ_WORD: begin
                    mem[idx0_s] <= wdata_q[31:24];
                    mem[idx1_s] <= wdata_q[23:16];
                    mem[idx2_s] <= wdata_q[15:8];
                    mem[idx3_s] <= wdata_q[7:0];
                end
                default: ;
            endcase
        end
    end

    // Handshake FSM with request capture, latency count and registered outputs.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 4'd0;
            rw_q       <= 1'b1;
            size_q     <= 2'b00;
            sign_q     <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= 32'h0000_0000;
            data_out_q <= 32'h0000_0000;
            moc_q      <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    moc_q <= 1'b0;
                    err_q <= 1'b0;
                    if (MOV) begin
                        rw_q    <= RW;
                        size_q  <= size;
                        sign_q  <= sign;
                        addr_q  <= addr[AW-1:0];
                        wdata_q <= data_in;
                        cnt_q   <= CNT_INIT;
                        state_q <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (!MOV) begin
                        state_q <= ST_IDLE;
                    end else if (cnt_q != 4'd0) begin
                        cnt_q <= cnt_q - 4'd1;
                    end else begin
                        moc_q   <= 1'b1;
                        err_q   <= err_s;
                        state_q <= ST_DONE;
                        if (err_s) begin
                            data_out_q <= 32'h0000_0000;
                        end else if (rw_q) begin
                            data_out_q <= rdata_s;
                        end
                    end
                end
                ST_DONE: begin
                    if (!MOV) begin
                        moc_q   <= 1'b0;
                        err_q   <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    moc_q   <= 1'b0;
                    err_q   <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign data_out = data_out_q;
    assign MOC      = moc_q;
    assign ERR      = err_q;

endmodule

// File: tb/tb_memory_responder.sv
// Bench for memory_responder: two instances (LATENCY=2 and LATENCY=1) driven
// independently, checked against a byte-array reference model.
module tb_memory_responder;

    localparam int NU    = 2;
    localparam int DEPTH = 512;
    localparam int LAT0  = 2;
    localparam int LAT1  = 1;

    logic        clk = 1'b0;
    logic        clr;
    logic        mov_s  [NU];
    logic        rw_s   [NU];
    logic [1:0]  size_s [NU];
    logic        sign_s [NU];
    logic [31:0] addr_s [NU];
    logic [31:0] din_s  [NU];
    logic [31:0] dout_o [NU];
    logic        moc_o  [NU];
    logic        err_o  [NU];

    int          checks   = 0;
    int          failures = 0;
    logic [7:0]  ref_mem   [NU][DEPTH];
    logic [31:0] exp_dout  [NU];
    logic [31:0] last_dout [NU];
    logic        last_err  [NU];
    time         rise_t    [NU];
    time         t0;

    memory_responder #(.DEPTH(DEPTH), .LATENCY(LAT0)) u_dut_l2 (
        .clk(clk), .clr(clr), .MOV(mov_s[0]), .RW(rw_s[0]), .size(size_s[0]),
        .sign(sign_s[0]), .addr(addr_s[0]), .data_in(din_s[0]),
        .data_out(dout_o[0]), .MOC(moc_o[0]), .ERR(err_o[0])
    );

    memory_responder #(.DEPTH(DEPTH), .LATENCY(LAT1)) u_dut_l1 (
        .clk(clk), .clr(clr), .MOV(mov_s[1]), .RW(rw_s[1]), .size(size_s[1]),
        .sign(sign_s[1]), .addr(addr_s[1]), .data_in(din_s[1]),
        .data_out(dout_o[1]), .MOC(moc_o[1]), .ERR(err_o[1])
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic put_mem(input int u, input int i, input logic [7:0] v);
        ref_mem[u][i] = v;
        if (u == 0) u_dut_l2.mem[i] = v;
        else        u_dut_l1.mem[i] = v;
    endtask

    function automatic int mem_diffs(input int u);
        int n;
        n = 0;
        for (int i = 0; i < DEPTH; i++) begin
            if (u == 0) begin
                if (u_dut_l2.mem[i] !== ref_mem[u][i]) n++;
            end else begin
                if (u_dut_l1.mem[i] !== ref_mem[u][i]) n++;
            end
        end
        return n;
    endfunction

    // Reference model: decides error, updates model RAM, computes read data.
    function automatic void model_access(input int u, input logic rw, input logic [1:0] sz,
                                         input logic sg, input logic [31:0] a,
                                         input logic [31:0] d, output logic err);
        int     base;
        int     nb;
        longint val;
        base = int'(a % 32'(DEPTH));
        err  = (sz == 2'd3) || (sz == 2'd1 && base % 2 != 0) || (sz == 2'd2 && base % 4 != 0);
        if (err) begin
            exp_dout[u] = 32'd0;
            return;
        end
        nb = 1 << sz;
        if (rw) begin
            val = 0;
            for (int i = 0; i < nb; i++) val = val * 256 + longint'(ref_mem[u][base + i]);
            if (sg && nb < 4 && val >= (longint'(1) << (8 * nb - 1)))
                val = val - (longint'(1) << (8 * nb));
            exp_dout[u] = val[31:0];
        end else begin
            for (int i = 0; i < nb; i++)
                ref_mem[u][base + i] = 8'((d >> (8 * (nb - 1 - i))) & 32'hFF);
        end
    endfunction

    task automatic scramble(input int u);
        rw_s[u]   = 1'($urandom);
        size_s[u] = 2'($urandom);
        sign_s[u] = 1'($urandom);
        addr_s[u] = $urandom;
        din_s[u]  = $urandom;
    endtask

    task automatic do_req(input int u, input logic rw, input logic [1:0] sz, input logic sg,
                          input logic [31:0] a, input logic [31:0] d);
        logic exp_err;
        int   lat;
        lat = (u == 0) ? LAT0 : LAT1;
        mov_s[u] = 1'b1; rw_s[u] = rw; size_s[u] = sz; sign_s[u] = sg;
        addr_s[u] = a; din_s[u] = d;
        @(posedge clk); #1;
        chk1($sformatf("u%0d moc_after_capture", u), moc_o[u], 1'b0);
        scramble(u);
        model_access(u, rw, sz, sg, a, d, exp_err);
        for (int n = 1; n <= lat; n++) begin
            @(posedge clk); #1;
            chk1($sformatf("u%0d moc_edge_k+%0d", u, n), moc_o[u], (n == lat));
        end
        rise_t[u]    = $time;
        last_dout[u] = dout_o[u];
        last_err[u]  = err_o[u];
        chk1($sformatf("u%0d err", u), err_o[u], exp_err);
        chk32($sformatf("u%0d data_out", u), dout_o[u], exp_dout[u]);
        mov_s[u] = 1'b0;
        @(posedge clk); #1;
        chk1($sformatf("u%0d moc_release", u), moc_o[u], 1'b0);
        chk1($sformatf("u%0d err_release", u), err_o[u], 1'b0);
        chk32($sformatf("u%0d data_out_hold", u), dout_o[u], exp_dout[u]);
    endtask

    task automatic do_abort(input int u, input logic rw, input logic [1:0] sz, input logic sg,
                            input logic [31:0] a, input logic [31:0] d);
        mov_s[u] = 1'b1; rw_s[u] = rw; size_s[u] = sz; sign_s[u] = sg;
        addr_s[u] = a; din_s[u] = d;
        @(posedge clk); #1;
        mov_s[u] = 1'b0;
        scramble(u);
        @(posedge clk); #1;
        chk1($sformatf("u%0d abort_moc", u), moc_o[u], 1'b0);
        chk1($sformatf("u%0d abort_err", u), err_o[u], 1'b0);
        chk32($sformatf("u%0d abort_dout", u), dout_o[u], exp_dout[u]);
        @(posedge clk); #1;
        chk1($sformatf("u%0d abort_moc_late", u), moc_o[u], 1'b0);
    endtask

    initial begin
        clr = 1'b1;
        for (int u = 0; u < NU; u++) begin
            mov_s[u] = 1'b0; rw_s[u] = 1'b1; size_s[u] = 2'b00; sign_s[u] = 1'b0;
            addr_s[u] = 32'd0; din_s[u] = 32'd0; exp_dout[u] = 32'd0;
            rise_t[u] = 0; last_dout[u] = 32'd0; last_err[u] = 1'b0;
        end
        #2 clr = 1'b0;
        #1;
        for (int u = 0; u < NU; u++) begin
            chk1($sformatf("u%0d reset_moc", u), moc_o[u], 1'b0);
            chk1($sformatf("u%0d reset_err", u), err_o[u], 1'b0);
            chk32($sformatf("u%0d reset_dout", u), dout_o[u], 32'd0);
        end
        for (int u = 0; u < NU; u++) begin
            for (int i = 0; i < DEPTH; i++) put_mem(u, i, 8'($urandom));
            put_mem(u, 0, 8'hDE); put_mem(u, 1, 8'hAD); put_mem(u, 2, 8'hBE); put_mem(u, 3, 8'hEF);
        end
        put_mem(0, 4, 8'h00);
        put_mem(1, 4, 8'h01); put_mem(1, 5, 8'h02); put_mem(1, 6, 8'h03); put_mem(1, 7, 8'h04);
        #10 clr = 1'b1;
        @(posedge clk); #1;

        // LATENCY=2 instance: reads, writes, errors, abort
        do_req(0, 1'b1, 2'b10, 1'b0, 32'h0, 32'h0);
        chk32("word_read_0", last_dout[0], 32'hDEADBEEF);
        chk1("word_read_0_err", last_err[0], 1'b0);
        do_req(0, 1'b1, 2'b00, 1'b1, 32'h1, 32'h0);
        chk32("byte_read_sx", last_dout[0], 32'hFFFFFFAD);
        do_req(0, 1'b1, 2'b00, 1'b0, 32'h1, 32'h0);
        chk32("byte_read_zx", last_dout[0], 32'h000000AD);
        do_req(0, 1'b1, 2'b01, 1'b1, 32'h2, 32'h0);
        chk32("half_read_sx", last_dout[0], 32'hFFFFBEEF);
        do_req(0, 1'b0, 2'b00, 1'b0, 32'h5, 32'hFFFFFF12);
        chk32("write_keeps_dout", last_dout[0], 32'hFFFFBEEF);
        do_req(0, 1'b0, 2'b01, 1'b0, 32'h6, 32'hABCD3456);
        do_req(0, 1'b1, 2'b10, 1'b0, 32'h4, 32'h0);
        chk32("write_readback", last_dout[0], 32'h00123456);
        do_req(0, 1'b0, 2'b10, 1'b0, 32'h2, 32'h11223344);
        chk1("mis_word_wr_err", last_err[0], 1'b1);
        chk32("mis_word_wr_dout", last_dout[0], 32'h0);
        do_req(0, 1'b1, 2'b01, 1'b0, 32'h3, 32'h0);
        chk1("mis_half_rd_err", last_err[0], 1'b1);
        do_req(0, 1'b1, 2'b11, 1'b0, 32'h0, 32'h0);
        chk1("reserved_size_err", last_err[0], 1'b1);
        chk32("reserved_size_dout", last_dout[0], 32'h0);
        chk32("mem_0_3_intact", {u_dut_l2.mem[0], u_dut_l2.mem[1], u_dut_l2.mem[2], u_dut_l2.mem[3]},
              32'hDEADBEEF);
        do_req(0, 1'b1, 2'b10, 1'b0, 32'h0, 32'h0);
        do_abort(0, 1'b0, 2'b10, 1'b0, 32'h8, 32'hCAFEF00D);
        chk32("u0 mem_after_abort", 32'(mem_diffs(0)), 32'd0);

        // LATENCY=1 instance: wrap, back-to-back, abort racing cnt==0
        do_req(1, 1'b1, 2'b10, 1'b0, 32'h0000_0204, 32'h0);
        chk32("wrap_read", last_dout[1], 32'h01020304);
        do_req(1, 1'b1, 2'b10, 1'b0, 32'h0, 32'h0);
        t0 = rise_t[1];
        chk32("b2b_first", last_dout[1], 32'hDEADBEEF);
        do_req(1, 1'b1, 2'b10, 1'b0, 32'h4, 32'h0);
        chk32("b2b_second", last_dout[1], 32'h01020304);
        chk32("b2b_gap", 32'(rise_t[1] - t0), 32'd30);
        do_abort(1, 1'b0, 2'b10, 1'b0, 32'h8, 32'hCAFEF00D);
        chk32("u1 mem_after_abort", 32'(mem_diffs(1)), 32'd0);

        // Reset while BUSY on a pending write
        mov_s[0] = 1'b1; rw_s[0] = 1'b0; size_s[0] = 2'b10; sign_s[0] = 1'b0;
        addr_s[0] = 32'h8; din_s[0] = 32'hCAFEF00D;
        @(posedge clk); #1;
        #1 clr = 1'b0;
        #1;
        chk1("rst_busy_moc", moc_o[0], 1'b0);
        chk1("rst_busy_err", err_o[0], 1'b0);
        chk32("rst_busy_dout0", dout_o[0], 32'h0);
        chk32("rst_busy_dout1", dout_o[1], 32'h0);
        exp_dout[0] = 32'd0;
        exp_dout[1] = 32'd0;
        mov_s[0] = 1'b0;
        #1 clr = 1'b1;
        @(posedge clk); #1;
        chk1("rst_busy_moc_after", moc_o[0], 1'b0);
        chk32("u0 mem_after_reset", 32'(mem_diffs(0)), 32'd0);

        // Randomized traffic against the model
        for (int it = 0; it < 40; it++) begin
            int          u;
            logic [31:0] a;
            logic [1:0]  sz;
            u  = int'($urandom_range(0, 1));
            sz = 2'($urandom_range(0, 3));
            a  = $urandom;
            if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
            if ($urandom_range(0, 5) == 0)
                do_abort(u, 1'($urandom), sz, 1'($urandom), a, $urandom);
            else
                do_req(u, 1'($urandom), sz, 1'($urandom), a, $urandom);
        end
        chk32("u0 mem_final", 32'(mem_diffs(0)), 32'd0);
        chk32("u1 mem_final", 32'(mem_diffs(1)), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
